// File: rtl/rr_select4.sv
// Four-requester round-robin arbiter with a registered output slot and valid/ready handshakes.
// The combinational grant index drives the downstream mux4 select.
module rr_select4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         req_valid,
  input  logic [4*WIDTH-1:0] req_data,
  output logic [3:0]         req_ready,
  output logic [1:0]         sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_src,
  input  logic               out_ready
);

  logic [1:0]       ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_src_q, out_src_d;

  logic [7:0]       req_dbl;
  logic [2:0]       rot_amt;
  logic [3:0]       req_rot;
  logic [1:0]       rot_off;
  logic             grant_found;
  logic [1:0]       grant_idx;
  logic             free;
  logic             xfer;

  // Rotate so that bit 0 is the requester just after the last grant,
  // then a fixed priority encoder picks the first one.
  assign req_dbl = {req_valid, req_valid};
  assign rot_amt = {1'b0, ptr_q} + 3'd1;
  assign req_rot = req_dbl[rot_amt +: 4];

  always_comb begin
    rot_off     = 2'd0;
    grant_found = 1'b1;
    if (req_rot[0])      rot_off = 2'd0;
    else if (req_rot[1]) rot_off = 2'd1;
    else if (req_rot[2]) rot_off = 2'd2;
    else if (req_rot[3]) rot_off = 2'd3;
    else                 grant_found = 1'b0;
  end

  assign grant_idx = ptr_q + 2'd1 + rot_off;
  assign free      = !out_valid_q || out_ready;
  assign xfer      = free && grant_found;

  assign sel       = grant_found ? grant_idx : ptr_q;
  assign req_ready = xfer ? (4'b0001 << grant_idx) : 4'b0000;

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (xfer) begin
      ptr_d       = grant_idx;
      out_valid_d = 1'b1;
      out_data_d  = req_data[int'(grant_idx) * WIDTH +: WIDTH];
      out_src_d   = grant_idx;
    end else if (free) begin
      // Slot drained with nothing to replace it; data/src keep their last value.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= 2'd3;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 2'd0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_select4.sv
// Bench for rr_select4: a per-cycle behavioural model compared on every falling edge,
// plus directed scenarios with hand-computed expectations.
module tb_rr_select4;

  localparam int WIDTH = 8;

  logic               clk;
  logic               reset_n;
  logic [3:0]         req_valid;
  logic [4*WIDTH-1:0] req_data;
  logic [3:0]         req_ready;
  logic [1:0]         sel;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_src;
  logic               out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  rr_select4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: last-grant pointer and the contents of the output slot.
  int               m_ptr;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic [1:0]       m_src;

  // First valid requester found walking forward from the one after ptr; -1 if none.
  function automatic int model_grant(input int ptr, input logic [3:0] rv);
    for (int k = 1; k <= 4; k++) begin
      if (rv[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ptr   <= 3;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_src   <= 2'd0;
    end else begin
      int g;
      logic fr;
      g  = model_grant(m_ptr, req_valid);
      fr = !m_valid || out_ready;
      if (fr && g >= 0) begin
        m_ptr   <= g;
        m_valid <= 1'b1;
        m_data  <= req_data[g*WIDTH +: WIDTH];
        m_src   <= 2'(g);
      end else if (fr) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic fr;
    logic [3:0] exp_ready;
    logic [1:0] exp_sel;
    g         = model_grant(m_ptr, req_valid);
    fr        = !m_valid || out_ready;
    exp_sel   = (g >= 0) ? 2'(g) : 2'(m_ptr);
    exp_ready = (fr && g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
    chk("cyc_out_data",  32'(out_data),  32'(m_data));
    chk("cyc_out_src",   32'(out_src),   32'(m_src));
    chk("cyc_sel",       32'(sel),       32'(exp_sel));
    chk("cyc_req_ready", 32'(req_ready), 32'(exp_ready));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b1;
    req_valid = 4'b1111;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_out_src",   32'(out_src),   32'h0);
    chk("rst_sel",       32'(sel),       32'h0);
    @(posedge clk);
    step();
    reset_n   = 1'b1;
    req_valid = 4'b0000;
    #1 chk("idle_sel_ptr", 32'(sel), 32'h3);

    // Single requester
    req_data  = {8'h13, 8'hA5, 8'h11, 8'h10};
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 32'(req_ready), 32'h4);
    chk("single_sel",   32'(sel),       32'h2);
    step();
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_data",  32'(out_data),  32'hA5);
    chk("single_src",   32'(out_src),   32'h2);
    req_valid = 4'b0000;
    step();
    chk("drain_valid", 32'(out_valid), 32'h0);

    // Park the pointer at 3, then full contention
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1000;
    step();
    chk("park_src", 32'(out_src), 32'h3);
    req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rot_src",  32'(out_src),  32'(i % 4));
      chk("rot_data", 32'(out_data), 32'(8'h10 + i % 4));
    end

    // Backpressure while holding 8'h11 from requester 1
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 32'h0);
      chk("bp_sel",   32'(sel),       32'h2);
      step();
      chk("bp_data",  32'(out_data),  32'h11);
      chk("bp_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(req_ready), 32'h4);
    step();
    chk("bp_release_src",  32'(out_src),  32'h2);
    chk("bp_release_data", 32'(out_data), 32'h12);

    // Skip and wrap
    req_valid = 4'b1000;
    step();
    chk("wrap_setup_src", 32'(out_src), 32'h3);
    req_valid = 4'b1001;
    #1 chk("wrap_sel0", 32'(sel), 32'h0);
    step();
    chk("wrap_src0", 32'(out_src), 32'h0);
    #1 chk("wrap_sel3", 32'(sel), 32'h3);
    step();
    chk("wrap_src3", 32'(out_src), 32'h3);
    req_valid = 4'b0011;
    #1 chk("wrap_sel_back", 32'(sel), 32'h0);
    step();
    chk("wrap_src_back", 32'(out_src), 32'h0);

    // Asynchronous reset in the middle of a held transfer
    req_data  = {8'h13, 8'h12, 8'h33, 8'h10};
    req_valid = 4'b0010;
    step();
    chk("mid_data",  32'(out_data),  32'h33);
    chk("mid_valid", 32'(out_valid), 32'h1);
    req_valid = 4'b0000;
    out_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_data",  32'(out_data),  32'h0);
    req_valid = 4'b1111;
    out_ready = 1'b1;
    step();
    reset_n = 1'b1;
    #1 chk("post_rst_sel", 32'(sel), 32'h0);
    step();
    chk("post_rst_src",  32'(out_src),  32'h0);
    chk("post_rst_data", 32'(out_data), 32'h10);
    step();
    chk("post_rst_src1", 32'(out_src), 32'h1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
